// File: rtl/pa_ifu_tag_pkg.sv
// Shared definitions for the IFU tag-array access controller:
// FSM state encoding, default geometry and macro write-enable constants.
package pa_ifu_tag_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 43;
    localparam int DEF_DEPTH      = 128;

    typedef enum logic {
        INV  = 1'b0,
        IDLE = 1'b1
    } tag_state_t;

    // Active-low macro WEN: all ones = no bit written, all zeros = every bit.
    localparam logic [DEF_DATA_WIDTH-1:0] WEN_ALL1 = '1;
    localparam logic [DEF_DATA_WIDTH-1:0] WEN_ALL0 = '0;

endpackage

// File: rtl/pa_ifu_tag_inv_cnt.sv
// Invalidation sweep index counter: clears, increments, wraps, flags last.
// Ports: clk, rst (async high), clr, inc, cnt (current index), last.
module pa_ifu_tag_inv_cnt
    import pa_ifu_tag_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    assign last = (cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            // Explicit wrap keeps non-power-of-two depths correct.
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pa_ifu_tag_array_ctrl.sv
// IFU tag SRAM access controller: reset/requested zero sweep, write-over-read
// arbitration, active-low macro pin generation, one-cycle read return.
// Ports: forever_cpuclk, cpurst (async high); inv_req/inv_busy;
//   wr_req/wr_idx/wr_data/wr_mask/wr_gnt; rd_req/rd_idx/rd_gnt/rd_vld/rd_data;
//   macro pins sram_a/sram_cen/sram_gwen/sram_wen/sram_d, sram_q.
// Option macro PA_IFU_TAG_RD_HOLD_EN: rd_data holds the last read result.
module pa_ifu_tag_array_ctrl
    import pa_ifu_tag_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  inv_req,
    output logic                  inv_busy,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    tag_state_t            state;
    tag_state_t            state_nxt;
    logic                  cnt_clr;
    logic                  cnt_inc;
    logic                  cnt_last;
    logic [ADDR_WIDTH-1:0] cnt;

    pa_ifu_tag_inv_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_inv_cnt (
        .clk  (forever_cpuclk),
        .rst  (cpurst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state <= INV;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        inv_busy  = 1'b0;
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        sram_a    = '0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        unique case (state)
            INV: begin
                inv_busy  = 1'b1;
                sram_a    = cnt;
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                cnt_inc   = 1'b1;
                if (cnt_last) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (inv_req) begin
                    state_nxt = INV;
                    cnt_clr   = 1'b1;
                end else if (wr_req) begin
                    wr_gnt    = 1'b1;
                    sram_a    = wr_idx;
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = ~wr_mask;
                    sram_d    = wr_data;
                end else if (rd_req) begin
                    rd_gnt    = 1'b1;
                    sram_a    = rd_idx;
                    sram_cen  = 1'b0;
                end
            end
            default: begin
                state_nxt = INV;
                cnt_clr   = 1'b1;
            end
        endcase
        // Keep the macro quiescent while reset is asserted; the state
        // register already sits in INV and would otherwise enable it.
        if (cpurst) begin
            sram_cen  = 1'b1;
            sram_gwen = 1'b1;
            sram_wen  = '1;
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_gnt;
        end
    end

`ifdef PA_IFU_TAG_RD_HOLD_EN
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            hold_q <= '0;
        end else if (rd_vld) begin
            hold_q <= sram_q;
        end
    end

    // Bypass in the return cycle so latency matches the unheld build.
    assign rd_data = rd_vld ? sram_q : hold_q;
`else
    assign rd_data = sram_q;
`endif

endmodule
